x_capture_sequencer: RTL

// - Controller between delay-line sampling and byte-level UART TX. On a trigger, snapshots i_data on
//   p_samples consecutive clocks into a local buffer, then streams header + buffered bytes over a

---
 rtl/x_capture_pkg.sv | 20 ++
 rtl/x_capture_buf.sv | 43 ++++
 rtl/x_capture_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/x_capture_pkg.sv
// Shared types and constants for the capture sequencer.
// Consumed by x_capture_sequencer and x_capture_buf.
package x_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_HEADER  = 3'd2,
        ST_DATA    = 3'd3,
        ST_CHECK   = 3'd4
    } capture_sm_t;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    // Counter width for a given range, never below one bit.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/x_capture_buf.sv
// Capture buffer: p_samples x p_length registers, one write port and a
// combinational byte-wide read port addressed by (sample, byte).
module x_capture_buf
    import x_capture_pkg::*;
#(
    parameter int p_length  = 32,
    parameter int p_samples = 4,
    parameter int SW        = cnt_width(p_samples),
    parameter int BW        = cnt_width(p_length / 8)
) (
    input  logic                i_clk,
    input  logic                i_nrst,
    input  logic                i_wr_en,
    input  logic [SW-1:0]       i_wr_addr,
    input  logic [p_length-1:0] i_wr_data,
    input  logic [SW-1:0]       i_rd_sample,
    input  logic [BW-1:0]       i_rd_byte,
    output logic [7:0]          o_rd_byte
);

    localparam int NB = p_length / 8;

    logic [p_length-1:0] r_mem [p_samples];

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int s = 0; s < p_samples; s++) r_mem[s] <= '0;
        end else if (i_wr_en) begin
            for (int s = 0; s < p_samples; s++)
                if (i_wr_addr == SW'(s)) r_mem[s] <= i_wr_data;
        end
    end

    // Mux over constant indices so non-power-of-two depths never index out of range.
    always_comb begin
        o_rd_byte = 8'h00;
        for (int s = 0; s < p_samples; s++)
            for (int b = 0; b < NB; b++)
                if (i_rd_sample == SW'(s) && i_rd_byte == BW'(b))
                    o_rd_byte = r_mem[s][b*8 +: 8];
    end

endmodule

// File: rtl/x_capture_sequencer.sv
// Burst capture of the delay line, streamed as header + data bytes to UART TX.
// Optional trailing XOR checksum byte when X_CAPTURE_CHECKSUM_EN is defined.
//
// state   | meaning
// IDLE    | waiting for i_trig
// CAPTURE | writing one i_data snapshot per cycle into the buffer
// HEADER  | offering p_header
// DATA    | offering buffered bytes, LSB byte first, sample 0 first
// CHECK   | offering XOR of all data bytes (checksum build only)
module x_capture_sequencer
    import x_capture_pkg::*;
#(
    parameter int         p_length  = 32,
    parameter int         p_samples = 4,
    parameter logic [7:0] p_header  = DEFAULT_HEADER
) (
    input  logic                i_clk,
    input  logic                i_nrst,
    input  logic [p_length-1:0] i_data,
    input  logic                i_trig,
    input  logic                i_tx_ready,
    output logic                o_tx_valid,
    output logic [7:0]          o_tx_data,
    output logic                o_busy,
    output logic                o_overrun
);

    localparam int NB = p_length / 8;
    localparam int SW = cnt_width(p_samples);
    localparam int BW = cnt_width(NB);

    capture_sm_t   r_state, w_state_nxt;
    logic [SW-1:0] r_sample_cnt;   // capture write address, then DATA read sample
    logic [BW-1:0] r_byte_idx;
    logic          r_overrun;
    logic [7:0]    w_rd_byte;
    logic          w_last_sample;
    logic          w_last_byte;
    logic          w_xfer;

`ifdef X_CAPTURE_CHECKSUM_EN
    logic [7:0]    r_csum;
`endif

    x_capture_buf #(
        .p_length  (p_length),
        .p_samples (p_samples),
        .SW        (SW),
        .BW        (BW)
    ) u_buf (
        .i_clk       (i_clk),
        .i_nrst      (i_nrst),
        .i_wr_en     (r_state == ST_CAPTURE),
        .i_wr_addr   (r_sample_cnt),
        .i_wr_data   (i_data),
        .i_rd_sample (r_sample_cnt),
        .i_rd_byte   (r_byte_idx),
        .o_rd_byte   (w_rd_byte)
    );

    assign w_last_sample = (r_sample_cnt == SW'(p_samples - 1));
    assign w_last_byte   = (r_byte_idx == BW'(NB - 1));
    assign w_xfer        = o_tx_valid & i_tx_ready;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_overrun     = r_overrun;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_tx_valid  = 1'b0;
        o_tx_data   = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (i_trig) w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (w_last_sample) w_state_nxt = ST_HEADER;
            end
            ST_HEADER: begin
                o_tx_valid = 1'b1;
                o_tx_data  = p_header;
                if (i_tx_ready) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                o_tx_valid = 1'b1;
                o_tx_data  = w_rd_byte;
                if (i_tx_ready && w_last_sample && w_last_byte)
`ifdef X_CAPTURE_CHECKSUM_EN
                    w_state_nxt = ST_CHECK;
`else
                    w_state_nxt = ST_IDLE;
`endif
            end
`ifdef X_CAPTURE_CHECKSUM_EN
            ST_CHECK: begin
                o_tx_valid = 1'b1;
                o_tx_data  = r_csum;
                if (i_tx_ready) w_state_nxt = ST_IDLE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_sample_cnt <= '0;
            r_byte_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE:    if (i_trig) r_sample_cnt <= '0;
                ST_CAPTURE: r_sample_cnt <= w_last_sample ? '0 : r_sample_cnt + SW'(1);
                ST_HEADER: begin
                    if (w_xfer) begin
                        r_sample_cnt <= '0;
                        r_byte_idx   <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        if (w_last_byte) begin
                            r_byte_idx   <= '0;
                            r_sample_cnt <= w_last_sample ? '0 : r_sample_cnt + SW'(1);
                        end else begin
                            r_byte_idx   <= r_byte_idx + BW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky until the next trigger that IDLE actually accepts.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)                           r_overrun <= 1'b0;
        else if (i_trig && r_state == ST_IDLE) r_overrun <= 1'b0;
        else if (i_trig)                       r_overrun <= 1'b1;
    end

`ifdef X_CAPTURE_CHECKSUM_EN
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)                             r_csum <= 8'h00;
        else if (w_xfer && r_state == ST_HEADER) r_csum <= 8'h00;
        else if (w_xfer && r_state == ST_DATA)   r_csum <= r_csum ^ w_rd_byte;
    end
`endif

endmodule
